nibble_serializer: RTL and testbench
====================================

NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 0, meaning 0 sends bit 0 first and 1 sends bit 3 first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream nibble present.
REQ-005 The block SHALL have port in_data, input, 4 bits: nibble to serialize.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts the nibble this cycle.
REQ-007 The block SHALL have port sel, output, 2 bits: current select index, the same code driven into the 4:1 mux.
REQ-008 The block SHALL have port data, output, 4 bits: latched nibble presented to the mux data input.
REQ-009 The block SHALL have port ser_out, output, 1 bit: mux output, equal to data[sel].
REQ-010 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a valid bit.
REQ-011 The block SHALL have port ser_ready, input, 1 bit: downstream consumes ser_out this cycle.
REQ-012 The block SHALL have port ser_last, output, 1 bit: the current bit is the fourth bit of the nibble.

Function
REQ-013 The block SHALL use two states: IDLE and SHIFT.
REQ-014 In IDLE, the block SHALL drive in_ready=1 and ser_valid=0.
REQ-015 A handshake in IDLE (in_valid & in_ready) SHALL latch in_data into data, clear the bit counter cnt to 0 and move to SHIFT on the next edge.
REQ-016 In SHIFT, the block SHALL drive ser_valid=1, with sel=cnt when MSB_FIRST=0 and sel=3-cnt when MSB_FIRST=1.
REQ-017 ser_out SHALL be combinational from data and sel, giving zero latency from sel to ser_out.
REQ-018 In SHIFT, cnt SHALL advance by 1 only on a cycle where ser_ready=1; while ser_ready=0, sel, data and ser_out SHALL hold.
REQ-019 ser_last SHALL be 1 exactly when the state is SHIFT and cnt=3.
REQ-020 In SHIFT, in_ready SHALL be 1 only on a cycle where cnt=3 and ser_ready=1, and 0 on every other SHIFT cycle.
REQ-021 When the last bit is accepted and in_valid=1, the block SHALL latch the new nibble, reset cnt to 0 and stay in SHIFT, with no bubble cycle between words.
REQ-022 When the last bit is accepted and in_valid=0, the block SHALL return to IDLE.
REQ-023 cnt SHALL be 2 bits wide and wrap from 3 to 0 only through REQ-021 or REQ-022.
REQ-024 in_data SHALL be ignored whenever in_ready=0.
REQ-025 A nibble SHALL always produce exactly 4 ser_valid&ser_ready beats.
REQ-026 The latency from the input handshake to the first ser_valid SHALL be 1 cycle.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set state=IDLE, cnt=0 and data=0.
REQ-028 While in reset, the outputs SHALL be ser_valid=0, ser_last=0, sel=0, ser_out=0, and in_ready=1 on the first cycle after reset.
REQ-029 A reset in mid-SHIFT SHALL discard the partial nibble, and no further bits of that nibble SHALL appear.
REQ-030 When rst and in_valid are both high, reset SHALL win and the nibble SHALL not be latched.

Structure
REQ-031 The state encoding (IDLE=0, SHIFT=1) and the constant NIBBLE_BITS=4 SHALL reside in the shared package mux_pkg.
REQ-032 The block SHALL instantiate the team's existing combinational 4:1 mux, module mux, as its single sub-module, with select=sel, data=data and out=ser_out.
REQ-033 All sequential logic SHALL reside in one clocked process, with next-state and ready logic kept combinational.

Verification
REQ-034 The bench SHALL cover: MSB_FIRST=0, in_data=4'b0101, ser_ready held 1 -> ser_out 1,0,1,0 on four consecutive cycles, sel 0,1,2,3, ser_last on the 4th cycle.
REQ-035 The bench SHALL cover: MSB_FIRST=1, in_data=4'b0111 -> ser_out 0,1,1,1, sel 3,2,1,0.
REQ-036 The bench SHALL cover: back-to-back nibbles 4'd1 then 4'd8 with in_valid held high -> 8 contiguous valid beats 1,0,0,0,0,0,0,1, with in_ready high only on the 4th beat.
REQ-037 The bench SHALL cover: ser_ready=0 for 3 cycles at cnt=2, in_data=4'd5 -> sel holds 2, ser_out holds 1, and the sequence resumes unchanged.
REQ-038 The bench SHALL cover: rst pulsed at cnt=1 during nibble 4'd7 -> ser_valid=0 on the next cycle, and in_ready=1 on the cycle after reset deasserts.
REQ-039 The bench SHALL cover: in_valid pulsed while in SHIFT with cnt<3 -> the nibble is not latched and data is unchanged.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the nibble serializer and its 4:1 output mux.
package mux_pkg;

  localparam int NIBBLE_BITS = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Mux select for a given bit count; MSB-first walks the nibble from bit 3 down.
  function automatic logic [1:0] sel_of(input logic [1:0] cnt, input bit msb_first);
    return msb_first ? (2'd3 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/mux.sv
// Combinational 4:1 mux: out is the data bit addressed by select.
module mux
  import mux_pkg::*;
(
  input  logic [1:0]             select,
  input  logic [NIBBLE_BITS-1:0] data,
  output logic                   out
);

  assign out = data[select];

endmodule

// File: rtl/nibble_serializer.sv
// Serializes 4-bit nibbles one bit per accepted beat through a 4:1 mux,
// accepting the next nibble on the last beat so words stream without a bubble.
module nibble_serializer
  import mux_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [NIBBLE_BITS-1:0] in_data,
  output logic                   in_ready,
  output logic [1:0]             sel,
  output logic [NIBBLE_BITS-1:0] data,
  output logic                   ser_out,
  output logic                   ser_valid,
  input  logic                   ser_ready,
  output logic                   ser_last,
  output state_e                 dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, while in_ready may depend on ser_ready.
  state_e                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [NIBBLE_BITS-1:0] data_q, data_d;
  logic                   last_beat;

  assign last_beat = (state_q == SHIFT) && (cnt_q == 2'd3) && ser_ready;
  assign in_ready  = (state_q == IDLE) || last_beat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      data_d  = in_data;
      cnt_d   = 2'd0;
      state_d = SHIFT;
    end else if (last_beat) begin
      cnt_d   = 2'd0;
      state_d = IDLE;
    end else if ((state_q == SHIFT) && ser_ready) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Select parks at 0 outside SHIFT so reset and idle present bit 0.
  assign sel         = (state_q == SHIFT) ? sel_of(cnt_q, MSB_FIRST) : 2'd0;
  assign data        = data_q;
  assign ser_valid   = (state_q == SHIFT);
  assign ser_last    = (state_q == SHIFT) && (cnt_q == 2'd3);
  assign dbg_state_o = state_q;

  mux u_mux (
    .select (sel),
    .data   (data_q),
    .out    (ser_out)
  );

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: LSB-first and MSB-first instances share stimulus
// and are checked against a queue-of-pending-bits reference model.
module tb_nibble_serializer;
  import mux_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid;
  logic [3:0] in_data;
  logic       ser_ready;

  logic       in_ready0, ser_out0, ser_valid0, ser_last0;
  logic [1:0] sel0;
  logic [3:0] data0;
  state_e     st0;
  logic       in_ready1, ser_out1, ser_valid1, ser_last1;
  logic [1:0] sel1;
  logic [3:0] data1;
  state_e     st1;

  nibble_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .sel(sel0), .data(data0), .ser_out(ser_out0),
    .ser_valid(ser_valid0), .ser_ready(ser_ready), .ser_last(ser_last0),
    .dbg_state_o(st0)
  );

  nibble_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .sel(sel1), .data(data1), .ser_out(ser_out1),
    .ser_valid(ser_valid1), .ser_ready(ser_ready), .ser_last(ser_last1),
    .dbg_state_o(st1)
  );

  // ---------------- scoreboard ----------------
  // Each entry is one pending output beat: {last, sel[1:0], bit}.
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  logic [3:0] exp_data;
  logic       after_rst;
  logic       check_en;
  int         n_checks;
  int         n_errors;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input string nm, input logic [3:0] head, input logic have,
                            input logic rdy, input logic vld, input logic lst,
                            input logic [1:0] s, input logic so, input logic [3:0] d,
                            input state_e st, input logic exp_rdy);
    check({nm, ".in_ready"}, {3'b0, rdy}, {3'b0, exp_rdy});
    check({nm, ".ser_valid"}, {3'b0, vld}, {3'b0, have});
    check({nm, ".state"}, {3'b0, st}, {3'b0, have});
    check({nm, ".data"}, d, exp_data);
    if (have) begin
      check({nm, ".ser_out"}, {3'b0, so}, {3'b0, head[0]});
      check({nm, ".sel"}, {2'b0, s}, {2'b0, head[2:1]});
      check({nm, ".ser_last"}, {3'b0, lst}, {3'b0, head[3]});
    end else begin
      check({nm, ".ser_last_idle"}, {3'b0, lst}, 4'h0);
      if (after_rst) begin
        check({nm, ".sel_rst"}, {2'b0, s}, 4'h0);
        check({nm, ".ser_out_rst"}, {3'b0, so}, 4'h0);
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are already set; check outputs mid-cycle, advance the model, cross the edge.
  task automatic step();
    logic       have;
    logic       exp_rdy;
    logic [3:0] h0;
    logic [3:0] h1;
    @(negedge clk);
    have    = (exp_q0.size() != 0);
    exp_rdy = (exp_q0.size() == 0) || ((exp_q0.size() == 1) && ser_ready);
    h0      = have ? exp_q0[0] : 4'h0;
    h1      = have ? exp_q1[0] : 4'h0;
    if (check_en) begin
      check_inst("lsb", h0, have, in_ready0, ser_valid0, ser_last0, sel0, ser_out0, data0, st0, exp_rdy);
      check_inst("msb", h1, have, in_ready1, ser_valid1, ser_last1, sel1, ser_out1, data1, st1, exp_rdy);
    end
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_data  = 4'h0;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (have && ser_ready) begin
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
      end
      if (in_valid && exp_rdy) begin
        exp_data = in_data;
        for (int i = 0; i < 4; i++) begin
          exp_q0.push_back({(i == 3), 2'(i), in_data[i]});
          exp_q1.push_back({(i == 3), 2'(3 - i), in_data[3 - i]});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] d, input logic sr, input int n);
    rst = r; in_valid = v; in_data = d; ser_ready = sr;
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    after_rst = 1'b0;
    exp_data  = 4'h0;
    check_en  = 1'b0;
    rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; ser_ready = 1'b0;
    @(posedge clk); #1;
    step();
    check_en = 1'b1;
    // reset held with in_valid high: nibble must not be latched
    drive(1'b1, 1'b1, 4'hF, 1'b1, 2);

    // single nibble 0101 with ser_ready held; then 0111
    drive(1'b0, 1'b1, 4'b0101, 1'b1, 1);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 5);
    drive(1'b0, 1'b1, 4'b0111, 1'b1, 1);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 5);

    // back-to-back 1 then 8 with in_valid held high
    drive(1'b0, 1'b1, 4'd1, 1'b1, 1);
    drive(1'b0, 1'b1, 4'd8, 1'b1, 4);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 5);

    // stall three cycles at cnt=2 with nibble 5
    drive(1'b0, 1'b1, 4'd5, 1'b1, 1);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 2);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 3);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 3);

    // reset at cnt=1 during nibble 7
    drive(1'b0, 1'b1, 4'd7, 1'b1, 1);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1);
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 3);

    // in_valid pulse mid-nibble is ignored
    drive(1'b0, 1'b1, 4'd3, 1'b1, 1);
    drive(1'b0, 1'b1, 4'hA, 1'b1, 1);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1);
    drive(1'b0, 1'b1, 4'hC, 1'b0, 1);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 4);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 4'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drive(1'b0, 1'b0, 4'h0, 1'b1, 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
